// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts an N-bit word over valid/ready and emits it
// one bit per shift_en cycle on so/so_valid, with gapless reload on the last bit.
module piso_serializer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic [N-1:0] pdata,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         shift_en,
    output logic         so,
    output logic         so_valid,
    output logic         busy,
    output logic         done,
    output logic         dbg_state
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_shreg;
    logic [N-1:0]    w_shreg_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_done;
    logic            w_done_nxt;
    logic            w_last;
    logic            w_out_bit;

    // Handshake: a word transfers on any edge with load_valid & load_ready.
    // load_ready is combinational in shift_en so upstream can refill on the
    // last-bit cycle; upstream must not derive shift_en from load_ready.
    assign w_last     = (r_state == ST_SHIFT) && (r_cnt == '0);
    assign load_ready = (r_state == ST_IDLE) || (w_last && shift_en);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_valid) begin
                    w_shreg_nxt = pdata;
                    w_cnt_nxt   = CNT_LAST;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (r_cnt != '0) begin
                        w_shreg_nxt = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
                        w_cnt_nxt   = r_cnt - CW'(1);
                    end else begin
                        w_done_nxt = 1'b1;
                        if (load_valid) begin
                            w_shreg_nxt = pdata;
                            w_cnt_nxt   = CNT_LAST;
                        end else begin
                            w_shreg_nxt = '0;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_shreg_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Serial outputs come only from registers; shreg is zero whenever idle.
    assign w_out_bit = MSB_FIRST ? r_shreg[N-1] : r_shreg[0];
    assign so        = w_out_bit && (r_state == ST_SHIFT);
    assign so_valid  = (r_state == ST_SHIFT);
    assign busy      = (r_state == ST_SHIFT);
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance
// share all stimulus; each output is checked against hand-derived values.
module tb_piso_serializer;

  logic       clk;
  logic       clear_n;
  logic [7:0] pdata;
  logic       load_valid;
  logic       shift_en;

  logic m_ready, m_so, m_valid, m_busy, m_done, m_state;
  logic l_ready, l_so, l_valid, l_busy, l_done, l_state;

  int n_cmp;
  int n_err;

  piso_serializer #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .clear_n(clear_n), .pdata(pdata), .load_valid(load_valid),
    .load_ready(m_ready), .shift_en(shift_en), .so(m_so), .so_valid(m_valid),
    .busy(m_busy), .done(m_done), .dbg_state(m_state)
  );

  piso_serializer #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .clear_n(clear_n), .pdata(pdata), .load_valid(load_valid),
    .load_ready(l_ready), .shift_en(shift_en), .so(l_so), .so_valid(l_valid),
    .busy(l_busy), .done(l_done), .dbg_state(l_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check both instances' common status outputs.
  task automatic chk_status(input string tag, input logic e_valid, input logic e_ready,
                            input logic e_done);
    chk({tag, " m_valid"}, m_valid, e_valid);
    chk({tag, " m_busy"},  m_busy,  e_valid);
    chk({tag, " m_state"}, m_state, e_valid);
    chk({tag, " m_ready"}, m_ready, e_ready);
    chk({tag, " m_done"},  m_done,  e_done);
    chk({tag, " l_valid"}, l_valid, e_valid);
    chk({tag, " l_busy"},  l_busy,  e_valid);
    chk({tag, " l_ready"}, l_ready, e_ready);
    chk({tag, " l_done"},  l_done,  e_done);
  endtask

  // Send one word from IDLE; optional stall of stall_len cycles while bit
  // stall_pos is on so. Mid-word load_valid pulses with junk pdata must be ignored.
  task automatic send_word(input string tag, input logic [7:0] w,
                           input int stall_pos, input int stall_len);
    @(negedge clk);
    pdata = w; load_valid = 1'b1; shift_en = 1'b1;
    #1;
    chk_status({tag, " accept"}, 1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 8; b++) begin
      if (b == stall_pos) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          pdata = 8'($urandom); load_valid = 1'b1; shift_en = 1'b0;
          #1;
          chk({tag, " stall m_so"}, m_so, w[7-b]);
          chk({tag, " stall l_so"}, l_so, w[b]);
          chk_status({tag, " stall"}, 1'b1, 1'b0, 1'b0);
        end
      end
      @(negedge clk);
      pdata = 8'($urandom);
      load_valid = (b < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      shift_en = 1'b1;
      #1;
      chk({tag, " m_so"}, m_so, w[7-b]);
      chk({tag, " l_so"}, l_so, w[b]);
      chk_status({tag, " bit"}, 1'b1, (b == 7), 1'b0);
    end
    @(negedge clk);
    load_valid = 1'b0; shift_en = 1'($urandom_range(0, 1));
    #1;
    chk({tag, " idle m_so"}, m_so, 1'b0);
    chk({tag, " idle l_so"}, l_so, 1'b0);
    chk_status({tag, " done"}, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    chk_status({tag, " after"}, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [15:0] pair;
    n_cmp = 0;
    n_err = 0;
    clear_n = 1'b0; pdata = 8'h00; load_valid = 1'b0; shift_en = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst m_so", m_so, 1'b0);
    chk("rst l_so", l_so, 1'b0);
    chk_status("rst", 1'b0, 1'b1, 1'b0);
    clear_n = 1'b1;

    // Shift_en ignored while idle
    @(negedge clk);
    shift_en = 1'b1;
    @(negedge clk);
    #1;
    chk_status("idle shift_en", 1'b0, 1'b1, 1'b0);

    // 8'hA5 streamed continuously (MSB and LSB first)
    send_word("a5", 8'hA5, -1, 0);

    // 8'hF0 with a 3-cycle stall while the 3rd bit is presented
    send_word("f0 stall", 8'hF0, 2, 3);

    // Random-looking word plus mid-word load attempts
    send_word("3c", 8'h3C, 5, 1);

    // Back-to-back 8'h81 then 8'h7E with load_valid held high
    pair = 16'h817E;
    @(negedge clk);
    pdata = 8'h81; load_valid = 1'b1; shift_en = 1'b1;
    #1;
    chk_status("b2b accept", 1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      pdata = (b < 8) ? 8'h7E : 8'h00;
      load_valid = (b < 8);
      #1;
      chk("b2b m_so", m_so, pair[15-b]);
      chk("b2b l_so", l_so, (b < 8) ? pair[8+b] : pair[b-8]);
      chk_status("b2b", 1'b1, (b == 7) || (b == 15), (b == 8));
    end
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    chk_status("b2b done", 1'b0, 1'b1, 1'b1);

    // Async reset mid-word, then no stale bits after release
    @(negedge clk);
    pdata = 8'hFF; load_valid = 1'b1; shift_en = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_status("pre-rst", 1'b1, 1'b0, 1'b0);
    clear_n = 1'b0;
    #1;
    chk("mid rst m_so", m_so, 1'b0);
    chk("mid rst l_so", l_so, 1'b0);
    chk_status("mid rst", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    clear_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("post rst m_so", m_so, 1'b0);
      chk("post rst l_so", l_so, 1'b0);
      chk_status("post rst", 1'b0, 1'b1, 1'b0);
    end

    // Normal operation after reset
    send_word("after rst", 8'h69, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
